// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit with HI/LO result registers; one step per clock.
// Optional MULTU/DIVU support is enabled by defining MULTDIV_UNSIGNED_EN.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
`ifdef MULTDIV_UNSIGNED_EN
    input  logic             op_unsigned,
`endif
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic             r_op;
    logic             r_neg_a;
    logic             r_neg_p;
    logic             r_dz;
    logic [WIDTH-1:0] r_mag_b;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic             r_busy;
    logic             r_done;
    logic             r_div_zero;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic               w_unsigned;
    logic               w_neg_a;
    logic               w_neg_b;
    logic               w_b_zero;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_step_hi;
    logic [WIDTH-1:0]   w_step_lo;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

`ifdef MULTDIV_UNSIGNED_EN
    assign w_unsigned = op_unsigned;
`else
    assign w_unsigned = 1'b0;
`endif

    // Magnitudes are W-bit unsigned so the most-negative operand still fits.
    assign w_neg_a  = op_a[WIDTH-1] & ~w_unsigned;
    assign w_neg_b  = op_b[WIDTH-1] & ~w_unsigned;
    assign w_mag_a  = w_neg_a ? (~op_a + {{(WIDTH-1){1'b0}}, 1'b1}) : op_a;
    assign w_mag_b  = w_neg_b ? (~op_b + {{(WIDTH-1){1'b0}}, 1'b1}) : op_b;
    assign w_b_zero = (op_b == {WIDTH{1'b0}});

    assign w_add   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_mag_b} : {(WIDTH+1){1'b0}});
    assign w_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_mag_b};

    assign w_prod     = {r_acc_hi, r_acc_lo};
    assign w_prod_fix = r_neg_p ? (~w_prod + {{(2*WIDTH-1){1'b0}}, 1'b1}) : w_prod;
    assign w_quo_fix  = r_neg_p ? (~r_acc_lo + {{(WIDTH-1){1'b0}}, 1'b1}) : r_acc_lo;
    assign w_rem_fix  = r_neg_a ? (~r_acc_hi + {{(WIDTH-1){1'b0}}, 1'b1}) : r_acc_hi;

    // One datapath step: shift-add for MULT, restoring shift-subtract for DIV.
    always_comb begin
        w_step_hi = r_acc_hi;
        w_step_lo = r_acc_lo;
        if (r_op == 1'b0) begin
            w_step_hi = w_add[WIDTH:1];
            w_step_lo = {w_add[0], r_acc_lo[WIDTH-1:1]};
        end else if (w_diff[WIDTH] == 1'b0) begin
            w_step_hi = w_diff[WIDTH-1:0];
            w_step_lo = {r_acc_lo[WIDTH-2:0], 1'b1};
        end else begin
            w_step_hi = w_shift[WIDTH-1:0];
            w_step_lo = {r_acc_lo[WIDTH-2:0], 1'b0};
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (op && w_b_zero) ? S_FINISH : S_RUN;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (r_cnt == LAST_STEP) begin
                    w_next = S_FINISH;
                end else begin
                    w_next = S_RUN;
                end
            end
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Operand capture, iteration and result write-back; HI/LO only move in FINISH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt      <= {CW{1'b0}};
            r_op       <= 1'b0;
            r_neg_a    <= 1'b0;
            r_neg_p    <= 1'b0;
            r_dz       <= 1'b0;
            r_mag_b    <= {WIDTH{1'b0}};
            r_acc_hi   <= {WIDTH{1'b0}};
            r_acc_lo   <= {WIDTH{1'b0}};
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= {WIDTH{1'b0}};
            r_lo       <= {WIDTH{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_busy     <= 1'b1;
                        r_div_zero <= 1'b0;
                        r_cnt      <= {CW{1'b0}};
                        r_op       <= op;
                        r_neg_a    <= w_neg_a;
                        r_neg_p    <= w_neg_a ^ w_neg_b;
                        r_dz       <= op & w_b_zero;
                        r_mag_b    <= w_mag_b;
                        r_acc_hi   <= {WIDTH{1'b0}};
                        r_acc_lo   <= w_mag_a;
                    end
                end
                S_RUN: begin
                    r_acc_hi <= w_step_hi;
                    r_acc_lo <= w_step_lo;
                    r_cnt    <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
                end
                S_FINISH: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    if (r_dz) begin
                        r_div_zero <= 1'b1;
                    end else if (r_op == 1'b0) begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end else begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end
                end
                default: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative signed multiply/divide unit for the multicycle datapath, directly downstream of the ALU operand-B select.
- Consumes operand A from the A register and operand B from the ALUSrcB select output.
- Runs MULT/DIV over WIDTH+1 clock edges and holds the results in HI/LO registers, which the control FSM reads after done.
- Control FSM issues start, then waits on done.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  request pulse; sampled only in IDLE.
- op  input  1  0 = MULT, 1 = DIV.
- op_a  input  WIDTH  operand A (A register).
- op_b  input  WIDTH  operand B (ALUSrcB select output).
- busy  output  1  operation in progress.
- done  output  1  one-cycle completion pulse.
- div_zero  output  1  last DIV had divisor 0.
- hi  output  WIDTH  MULT: product[2W-1:W]; DIV: remainder.
- lo  output  WIDTH  MULT: product[W-1:0]; DIV: quotient.

Behaviour:
- Reset is asynchronous and active-high.
  - State = IDLE; busy, done, div_zero, hi, lo, iteration counter and internal registers all go to 0.
  - Reset mid-operation aborts the operation; no done pulse follows.
- FSM states: IDLE, RUN, FINISH.
  - IDLE: on a clock edge with start=1 (edge E0), capture op, |op_a|, |op_b| and both sign bits; set busy=1; clear div_zero; clear counter; go to RUN.
  - DIV with op_b==0 at E0 goes to FINISH instead of RUN.
  - RUN: one shift-add (MULT) or restoring shift-subtract (DIV) step per edge, on magnitudes. After WIDTH steps (edges E1..E32 for WIDTH=32), go to FINISH.
  - FINISH: apply sign correction, write hi/lo, busy=0, done=1, return to IDLE. done falls on the next edge.
- Timing: normal ops pulse done during the cycle after edge E(WIDTH+1), i.e. E33 for WIDTH=32.
- Divide by zero:
  - FINISH is entered at E1; done and div_zero rise after E1.
  - hi and lo keep their previous values.
  - div_zero holds until the next accepted start.
- Signed rules:
  - MULT: full 2W-bit two's-complement product.
  - DIV: quotient truncates toward zero; remainder takes the dividend's sign.
  - Magnitudes use W-bit unsigned, so |-2^(W-1)| is representable.
  - Most-negative / -1 gives lo = 0x80000000 and hi = 0, with no flag.
- start while busy=1 is ignored, including during the FINISH cycle. op_a, op_b and op may change freely after E0.
- hi and lo change only in FINISH, never during RUN, so the datapath can read stale HI/LO while busy.
- A start sampled in the same cycle that done=1 (FSM already in IDLE) is accepted normally.

Optional Feature:
- Macro MULTDIV_UNSIGNED_EN.
- When defined:
  - Adds input port op_unsigned (1 bit, after op), captured at E0.
  - When op_unsigned=1, operands are treated as unsigned and sign correction is skipped (MULTU/DIVU).
  - Latency and div-zero rules are unchanged.
- When undefined: the port is absent and all operations are signed.

Test Plan:
- MULT, op_a=7, op_b=0xFFFFFFFD (-3), start at E0 -> busy through E32; done pulse after E33; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULT, op_a=op_b=0x80000000 -> hi=0x40000000, lo=0x00000000.
- DIV, op_a=0xFFFFFFF9 (-7), op_b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), div_zero=0.
- Preload hi/lo via MULT 3*5 (hi=0, lo=15), then DIV 5/0 -> done and div_zero=1 after E1; hi=0, lo=15 retained; next start clears div_zero.
- DIV 100/7 with start re-pulsed at E5 (MULT 2*2) -> second start ignored; hi=2, lo=14 after E33; one done pulse only.
- MULT 9*9 with reset asserted at E10 for one cycle -> all outputs 0 immediately, no done; fresh MULT 9*9 then gives lo=81, hi=0.
